// File: rtl/psr_flag_unit_if.sv
// Bundle of decode, writeback and direct-write signals between the pipeline
// and the status-flag unit, plus the flag/interlock outputs it returns.
interface psr_flag_if #(
  parameter int CNT_W = 2
);
  // Decode side
  logic             issue_valid;
  logic             issue_set;
  logic [3:0]       issue_cond;
  // Writeback side
  logic             wb_valid;
  logic             wb_pass;
  logic [3:0]       wb_nzcv;
  // Direct (MSR-style) write
  logic             msr_we;
  logic [3:0]       msr_nzcv;
  // Outputs of the flag unit
  logic             n_flag;
  logic             z_flag;
  logic             c_flag;
  logic             v_flag;
  logic             stall;
  logic [CNT_W-1:0] pending;
  logic             err;

  // Pipeline side: drives requests, observes flags and interlock.
  modport master (
    output issue_valid, issue_set, issue_cond,
    output wb_valid, wb_pass, wb_nzcv,
    output msr_we, msr_nzcv,
    input  n_flag, z_flag, c_flag, v_flag,
    input  stall, pending, err
  );

  // Flag unit side.
  modport slave (
    input  issue_valid, issue_set, issue_cond,
    input  wb_valid, wb_pass, wb_nzcv,
    input  msr_we, msr_nzcv,
    output n_flag, z_flag, c_flag, v_flag,
    output stall, pending, err
  );
endinterface

// File: rtl/psr_flag_unit.sv
// Architectural NZCV flag register with a pending-writer interlock.
// Flag-setting instructions in flight are counted; decode of any
// flag-reading instruction is stalled until that count is back to zero,
// which is exactly the cycle the last writeback's flags become visible.
module psr_flag_unit #(
  parameter int MAX_PENDING = 3,
  parameter int CNT_W       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  psr_flag_if.slave   bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

  // Reject counter limits the counter width cannot represent.
  generate
    if (MAX_PENDING < 1 || MAX_PENDING > (1 << CNT_W) - 1) begin : g_bad_param
      $error("psr_flag_unit: MAX_PENDING out of range for CNT_W");
    end
  endgenerate

  logic [3:0]       nzcv_q;
  logic [CNT_W-1:0] pend_q;
  logic             err_q;

  logic reads_flags;
  logic pend_zero;
  logic stall_c;
  logic accept;
  logic commit;
  logic msr_load;
  logic msr_drop;
  logic underflow;

  // Interlock and update-qualifier decode; reads only registered state
  // and issue/wb/msr inputs, never feeds wb/msr data to any output.
  always_comb begin
    // NOTE: every signal is assigned on every path of this block, so no
    // latch can be inferred.
    reads_flags = (bus.issue_cond[3:1] != 3'b111);   // AL and 1111 ignore flags
    pend_zero   = (pend_q == '0);
    stall_c     = bus.issue_valid &&
                  ((reads_flags && !pend_zero) ||
                   (bus.issue_set && (pend_q == MAX_CNT)));
    accept      = bus.issue_valid && bus.issue_set && !stall_c;
    commit      = bus.wb_valid && bus.wb_pass;
    msr_load    = bus.msr_we && !commit && pend_zero;
    msr_drop    = bus.msr_we && (commit || !pend_zero);
    underflow   = bus.wb_valid && pend_zero;
  end

  // In-flight flag-setter count: +1 on accepted issue, -1 on writeback,
  // net zero when both happen; never wraps below zero.
  always_ff @(posedge clk) begin
    // NOTE: rst_n is sampled only at the clock edge (synchronous reset),
    // and all state uses non-blocking assignments.
    if (!rst_n) begin
      pend_q <= '0;
    end else if (accept && !bus.wb_valid) begin
      pend_q <= pend_q + 1'b1;
    end else if (bus.wb_valid && !accept && !pend_zero) begin
      pend_q <= pend_q - 1'b1;
    end
  end

  // Flag register: writeback commit beats a direct write; a direct write
  // is only honoured when no flag setter is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nzcv_q <= 4'b0000;
    end else if (commit) begin
      nzcv_q <= bus.wb_nzcv;
    end else if (msr_load) begin
      nzcv_q <= bus.msr_nzcv;
    end
  end

  // Sticky protocol error: writeback underflow or a dropped direct write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (underflow || msr_drop) begin
      err_q <= 1'b1;
    end
  end

  assign bus.n_flag  = nzcv_q[3];
  assign bus.z_flag  = nzcv_q[2];
  assign bus.c_flag  = nzcv_q[1];
  assign bus.v_flag  = nzcv_q[0];
  assign bus.stall   = stall_c;
  assign bus.pending = pend_q;
  assign bus.err     = err_q;

endmodule
